mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-ported instruction/data memory between two requesters: the instruction-fetch path (I port) and the load/store data path (D port). It sequences each access through a fixed-latency memory, hides the wait states from the requesters with a req/ack handshake, and arbitrates when both request together. It sits between the multicycle control unit/datapath and the memory block, replacing hand-counted wait states in the controller.

## Interface
- `ADDR_W`, default 32: memory address width.
- `DATA_W`, default 32: memory data width.
- `WAIT_CYCLES`, default 2: read latency from address presented to `mem_rdata` valid; legal range 1..15.

- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `i_req`  in  1  fetch request; held high until `i_ack`.
- `i_addr`  in  ADDR_W  fetch address; stable while `i_req` is high.
- `i_rdata`  out  DATA_W  fetched word; valid while `i_ack` is high, held afterwards.
- `i_ack`  out  1  one-cycle completion pulse.
- `d_req`  in  1  data request; held high until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  loaded word; valid while `d_ack` is high, held afterwards.
- `d_ack`  out  1  one-cycle completion pulse.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered memory write data.
- `mem_wr`  out  1  memory write strobe, 1 = write, 0 = read.
- `mem_rdata`  in  DATA_W  memory read data.
- `busy`  out  1  high in every state except IDLE.
- `owner`  out  1  current or last grant, 0 = I, 1 = D.

## Operation
- States: IDLE, ISSUE, ACCESS, DONE.
- IDLE: samples `i_req` and `d_req`. If either is high, grants one requester and latches its address, its write data and its we into `mem_addr`, `mem_wdata` and an internal we. `owner` updates to the grantee. Next state is ISSUE. An I grant is always a read.
- ISSUE: `mem_addr` is valid. For a write, `mem_wr`=1 for this cycle only and the next state is DONE. For a read, `mem_wr`=0, the wait counter loads `WAIT_CYCLES`-1, and the next state is ACCESS.
- ACCESS: the counter decrements each cycle. When the counter is 0, `mem_rdata` is captured into the grantee's rdata register and the next state is DONE. ACCESS therefore lasts `WAIT_CYCLES` cycles.
- DONE: the grantee's ack is 1 for exactly one cycle. Both req inputs are ignored in this cycle. Next state is IDLE.
- The non-granted rdata register keeps its value.
- `mem_addr` and `mem_wdata` hold their last value in IDLE.
- Arbitration with one requester active: that requester is granted.
- Arbitration with both active: the policy is set under Configuration.
- Protocol violation: if req drops before ack, the granted access still completes and ack still pulses. The requester treats that ack as stale.
- Reset, asynchronous at any point including mid-access: state goes to IDLE with no ack for the aborted access. Reset values:
  - `mem_wr`=0, `i_ack`=`d_ack`=0, `busy`=0;
  - `mem_addr`=0, `mem_wdata`=0;
  - `i_rdata`=`d_rdata`=0;
  - `owner`=1 (D), so that I wins the first contested round-robin grant;
  - wait counter=0.

## Timing
- Request seen high in IDLE at cycle N. The grant registers at the edge ending N.
- Read: ISSUE at N+1, ACCESS from N+2 to N+1+`WAIT_CYCLES`, ack at N+2+`WAIT_CYCLES`. With default 2, ack is at N+4.
- Write: ISSUE with `mem_wr`=1 at N+1, ack at N+2.
- Back-to-back period: a read takes `WAIT_CYCLES`+3 cycles and a write takes 3 cycles, because IDLE is one cycle minimum.
- Requesters must drop or renew req in the cycle after ack. Req still high in IDLE after ack is treated as a new request.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: on contention, the port that was not `owner` wins. Grants alternate I, D, I, D while both requests stay high.
- `MEM_ARB_ROUND_ROBIN_EN` undefined: fixed priority, D always wins contention. `owner` is still reported.

## Test plan
- Fetch read: `i_req`=1, `i_addr`=0x40, memory returns 0xDEADBEEF, WAIT_CYCLES=2. Required: `mem_addr`=0x40 at N+1, `i_ack` high only at N+4, `i_rdata`=0xDEADBEEF, `d_ack` never high.
- Store: `d_req`=1, `d_we`=1, `d_addr`=0x100, `d_wdata`=0x12345678. Required: `mem_wr`=1 for exactly the N+1 cycle with the address and data driven, `d_ack` at N+2.
- Contention with round-robin defined, from reset: both reqs held high through 4 transactions. Required grant order I, D, I, D and `owner` toggling. With the macro undefined, all 4 grants go to D.
- Load after fetch: check that `i_rdata` holds its old value while `d_rdata` updates with the loaded word.
- Reset mid-read: assert reset in the ACCESS cycle. Required: immediate IDLE, `busy`=0, no ack, all outputs at reset values. A new `i_req` then completes normally with ack at N+4.
- WAIT_CYCLES=1 and WAIT_CYCLES=15 builds: read ack at N+3 and N+17 respectively, with `mem_rdata` captured on the last ACCESS cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one fixed-latency memory between fetch (I) and load/store (D).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise D has fixed priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StIssue, StAccess, StDone} state_e;

    localparam logic [3:0] CntLoad = 4'(WAIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic              owner_q, we_q, grant;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, i_rdata_q, d_rdata_q;

    // grant: 0 = I, 1 = D
    always_comb begin
        grant = owner_q;
        if (i_req && d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant = ~owner_q;
`else
            grant = 1'b1;
`endif
        end else if (i_req) begin
            grant = 1'b0;
        end else if (d_req) begin
            grant = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (i_req || d_req) state_d = StIssue;
            StIssue:  state_d = we_q ? StDone : StAccess;
            StAccess: if (cnt_q == 4'd0) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        mem_wr = 1'b0;
        busy   = 1'b1;
        i_ack  = 1'b0;
        d_ack  = 1'b0;
        unique case (state_q)
            StIdle:   busy = 1'b0;
            StIssue:  mem_wr = we_q;
            StAccess: ;
            StDone: begin
                i_ack = ~owner_q;
                d_ack = owner_q;
            end
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            owner_q   <= 1'b1;
            we_q      <= 1'b0;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_req || d_req) begin
                        owner_q <= grant;
                        we_q    <= grant & d_we;
                        addr_q  <= grant ? d_addr : i_addr;
                        if (grant) wdata_q <= d_wdata;
                    end
                end
                StIssue: begin
                    if (!we_q) cnt_q <= CntLoad;
                end
                StAccess: begin
                    if (cnt_q == 4'd0) begin
                        if (owner_q) d_rdata_q <= mem_rdata;
                        else         i_rdata_q <= mem_rdata;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    assign owner     = owner_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural fixed-latency memory.
module tb_mem_port_arbiter;

    localparam int unsigned W = 2;

    logic        clock, reset;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_word;
    logic        mem_wr, busy, owner;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(W)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: data is valid only on the W-th cycle after the issue cycle.
    int unsigned lat = 0;
    logic        wr_valid = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;

    always @(posedge clock) begin
        lat <= busy ? lat + 1 : 0;
        if (mem_wr) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
    end

    always_comb begin
        rd_word = mem_addr ^ 32'h5A5A_5A5A;
        if (mem_addr == 32'h40) rd_word = 32'hDEAD_BEEF;
        if (wr_valid && mem_addr == wr_addr) rd_word = wr_data;
        mem_rdata = (busy && !mem_wr && lat == W) ? rd_word : 32'hBAD0_BAD0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".busy"}, {31'b0, busy}, 32'd0);
        check({tag, ".acks"}, {30'b0, i_ack, d_ack}, 32'd0);
        check({tag, ".mem_wr"}, {31'b0, mem_wr}, 32'd0);
        check({tag, ".mem_addr"}, mem_addr, 32'h0);
        check({tag, ".mem_wdata"}, mem_wdata, 32'h0);
        check({tag, ".i_rdata"}, i_rdata, 32'h0);
        check({tag, ".d_rdata"}, d_rdata, 32'h0);
        check({tag, ".owner"}, {31'b0, owner}, 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Issues one transfer from an idle DUT and times the ack from the request cycle N.
    task automatic run_xfer(input string tag, input bit is_d, input bit we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata);
        int ack_at = -1;
        int other_acks = 0;
        int wr_cycles = 0;
        @(negedge clock);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        for (int k = 1; k <= int'(W) + 10 && ack_at < 0; k++) begin
            @(negedge clock);
            if (k == 1) begin
                check({tag, ".mem_addr"}, mem_addr, addr);
                check({tag, ".owner"}, {31'b0, owner}, {31'b0, is_d});
                if (we) check({tag, ".mem_wdata"}, mem_wdata, wdata);
            end
            if (mem_wr) wr_cycles++;
            if (is_d ? i_ack : d_ack) other_acks++;
            if (is_d ? d_ack : i_ack) begin
                ack_at = k;
                i_req  = 1'b0;
                d_req  = 1'b0;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check({tag, ".ack_cycle"}, 32'(ack_at), we ? 32'd2 : 32'(W + 2));
        check({tag, ".wr_cycles"}, 32'(wr_cycles), we ? 32'd1 : 32'd0);
        check({tag, ".other_ack"}, 32'(other_acks), 32'd0);
        if (!we) check({tag, ".rdata"}, is_d ? d_rdata : i_rdata, exp_rdata);
        @(negedge clock);
        check({tag, ".ack_drop"}, {30'b0, i_ack, d_ack}, 32'd0);
        check({tag, ".idle"}, {31'b0, busy}, 32'd0);
    endtask

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam logic [3:0]  ExpOrder  = 4'b1010;
    localparam logic [31:0] ExpIRdata = 32'h5A5A_5ADA;
`else
    localparam logic [3:0]  ExpOrder  = 4'b1111;
    localparam logic [31:0] ExpIRdata = 32'h0;
`endif

    initial begin
        int          n;
        int          stray;
        logic [3:0]  order;
        logic [3:0]  owners;

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        #12;
        check_reset_values("rst");
        @(negedge clock);
        reset = 1'b0;

        run_xfer("fetch", 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
        run_xfer("store", 1'b1, 1'b1, 32'h100, 32'h1234_5678, 32'h0);
        run_xfer("load", 1'b1, 1'b0, 32'h100, 32'h0, 32'h1234_5678);
        check("load.i_rdata_held", i_rdata, 32'hDEAD_BEEF);

        // Contention from reset with both requests held high.
        pulse_reset();
        n = 0; order = '0; owners = '0;
        i_req = 1'b1; i_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        for (int k = 0; k < 4 * (int'(W) + 3) + 10 && n < 4; k++) begin
            @(negedge clock);
            if (i_ack || d_ack) begin
                order[n]  = d_ack;
                owners[n] = owner;
                n++;
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("arb.count", 32'(n), 32'd4);
        check("arb.order", {28'b0, order}, {28'b0, ExpOrder});
        check("arb.owner", {28'b0, owners}, {28'b0, ExpOrder});
        check("arb.i_rdata", i_rdata, ExpIRdata);
        check("arb.d_rdata", d_rdata, 32'h5A5A_585A);

        // Reset asserted during ACCESS aborts the fetch without an ack.
        @(negedge clock);
        @(negedge clock);
        i_req = 1'b1; i_addr = 32'h40;
        @(negedge clock);
        @(negedge clock);
        check("abort.in_access", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        i_req = 1'b0;
        #1;
        check_reset_values("abort");
        @(negedge clock);
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < int'(W) + 4; k++) begin
            @(negedge clock);
            if (i_ack || d_ack || busy) stray++;
        end
        check("abort.quiet", 32'(stray), 32'd0);
        run_xfer("refetch", 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
